// File: rtl/pairing_pkg.sv
// Shared definitions for the pairing datapath: modular op codes and the default
// double-width BLS12-381 modulus.
package pairing_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_DBL = 2'd2,
        OP_NEG = 2'd3
    } modop_e;

    localparam int WORD_SIZE = 384;
    localparam int MOD_WIDTH = 2 * WORD_SIZE;

    localparam logic [WORD_SIZE-1:0] BLS381_CHAR =
        384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    // Characteristic shifted into the upper word (DP form).
    localparam logic [MOD_WIDTH-1:0] MODULUS_DEF = {BLS381_CHAR, {WORD_SIZE{1'b0}}};

    function automatic logic isSubLike(modop_e op);
        return (op == OP_SUB) || (op == OP_NEG);
    endfunction

endpackage

// File: rtl/addsubmod_pipe_modsel_stage.sv
// Second pipeline stage: picks the reduced candidate and holds it in the
// elastic output register.
module modsel_stage
    import pairing_pkg::*;
#(
    parameter int WIDTH = MOD_WIDTH,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_load,
    input  logic [WIDTH+1:0] i_r0,
    input  logic [WIDTH+1:0] i_r1,
    input  logic [1:0]       i_op,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_range,
    input  logic             i_negZero,
    input  logic             i_outReady,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_range
);

    logic             r_valid;
    logic [WIDTH-1:0] r_res;
    logic [TAG_W-1:0] r_tag;
    logic             r_range;
    logic [WIDTH-1:0] w_sel;
    modop_e           w_op;
    logic             w_unusedBits;

    assign w_op         = modop_e'(i_op);
    assign w_unusedBits = ^{i_r0[WIDTH+1], i_r1[WIDTH]};

    // ADD/DBL keep X+Y-P unless it went negative; SUB/NEG keep the raw
    // difference unless it borrowed. NEG of zero is forced to 0 rather than P.
    always_comb begin
        w_sel = i_r0[WIDTH-1:0];
        case (w_op)
            OP_ADD, OP_DBL: w_sel = i_r1[WIDTH+1] ? i_r0[WIDTH-1:0] : i_r1[WIDTH-1:0];
            default:        w_sel = i_r0[WIDTH]   ? i_r0[WIDTH-1:0] : i_r1[WIDTH-1:0];
        endcase
        if (i_negZero) begin
            w_sel = '0;
        end
    end

    assign o_load = !r_valid || i_outReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_res   <= '0;
            r_tag   <= '0;
            r_range <= 1'b0;
        end else if (o_load) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_res   <= w_sel;
                r_tag   <= i_tag;
                r_range <= i_range;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_res   = r_res;
    assign o_tag   = r_tag;
    assign o_range = r_range;

endmodule

// File: rtl/addsubmod_pipe.sv
// Two-stage elastic modular add/sub/double/negate unit; stage 1 forms both
// reduction candidates, stage 2 (modsel_stage) selects and presents the result.
module addsubmod_pipe
    import pairing_pkg::*;
#(
    parameter int               WIDTH   = MOD_WIDTH,
    parameter logic [WIDTH-1:0] MODULUS = MODULUS_DEF,
    parameter int               TAG_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_range
);

    localparam logic [WIDTH+1:0] ZERO_EXT    = '0;
    localparam logic [WIDTH+1:0] ONE_EXT     = {{(WIDTH+1){1'b0}}, 1'b1};
    localparam logic [WIDTH+1:0] P_EXT       = {2'b00, MODULUS};
    localparam logic [WIDTH+1:0] NEG_P_EXT   = ~P_EXT + ONE_EXT;
    localparam logic [WIDTH+1:0] P_PLUS1_EXT = P_EXT + ONE_EXT;

    modop_e           w_op;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_subLike;
    logic [WIDTH+1:0] w_xExt;
    logic [WIDTH+1:0] w_yExt;
    logic [WIDTH+1:0] w_r0;
    logic [WIDTH+1:0] w_r1;
    logic             w_range;
    logic             w_negZero;
    logic             w_s1Load;
    logic             w_s2Load;

    logic             r_s1Valid;
    logic [WIDTH+1:0] r_s1R0;
    logic [WIDTH+1:0] r_s1R1;
    logic [1:0]       r_s1Op;
    logic [TAG_W-1:0] r_s1Tag;
    logic             r_s1Range;
    logic             r_s1NegZero;

    assign w_op = modop_e'(in_op);

    // Subtraction-like ops become X + ~Y + 1 so both candidates are plain sums.
    always_comb begin
        w_x       = in_a;
        w_y       = in_b;
        w_subLike = 1'b0;
        case (w_op)
            OP_SUB: begin
                w_y       = ~in_b;
                w_subLike = 1'b1;
            end
            OP_DBL: w_y = in_a;
            OP_NEG: begin
                w_x       = MODULUS;
                w_y       = ~in_a;
                w_subLike = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_xExt    = {2'b00, w_x};
    assign w_yExt    = {2'b00, w_y};
    assign w_r0      = w_xExt + w_yExt + (w_subLike ? ONE_EXT : ZERO_EXT);
    assign w_r1      = w_xExt + w_yExt + (w_subLike ? P_PLUS1_EXT : NEG_P_EXT);
    assign w_range   = (in_a >= MODULUS) ||
                       ((in_b >= MODULUS) && ((w_op == OP_ADD) || (w_op == OP_SUB)));
    assign w_negZero = (w_op == OP_NEG) && (in_a == '0);

    assign w_s1Load = !r_s1Valid || w_s2Load;
    assign in_ready = w_s1Load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1Valid   <= 1'b0;
            r_s1R0      <= '0;
            r_s1R1      <= '0;
            r_s1Op      <= 2'd0;
            r_s1Tag     <= '0;
            r_s1Range   <= 1'b0;
            r_s1NegZero <= 1'b0;
        end else if (w_s1Load) begin
            r_s1Valid <= in_valid;
            if (in_valid) begin
                r_s1R0      <= w_r0;
                r_s1R1      <= w_r1;
                r_s1Op      <= in_op;
                r_s1Tag     <= in_tag;
                r_s1Range   <= w_range;
                r_s1NegZero <= w_negZero;
            end
        end
    end

    modsel_stage #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) u_modsel (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (r_s1Valid),
        .o_load     (w_s2Load),
        .i_r0       (r_s1R0),
        .i_r1       (r_s1R1),
        .i_op       (r_s1Op),
        .i_tag      (r_s1Tag),
        .i_range    (r_s1Range),
        .i_negZero  (r_s1NegZero),
        .i_outReady (out_ready),
        .o_valid    (out_valid),
        .o_res      (out_res),
        .o_tag      (out_tag),
        .o_range    (out_range)
    );

endmodule

// File: tb/tb_addsubmod_pipe.sv
// Scoreboard bench for addsubmod_pipe: beats are modelled when accepted and
// compared in order when the unit hands them downstream.
module tb_addsubmod_pipe;
    import pairing_pkg::*;

    localparam int W  = MOD_WIDTH;
    localparam int TW = 8;
    localparam int CW = W + 2;
    localparam logic [W-1:0] P = MODULUS_DEF;

    typedef logic [CW-1:0] cmp_t;

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          range;
        logic          chkRes;
        logic          chkLat;
        int            acceptCycle;
    } expect_t;

    expect_t scoreQ[$];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'd0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
    logic          out_range;

    int   assertCount = 0;
    int   failCount   = 0;
    int   cycleNum    = 0;
    int   acceptTotal = 0;
    int   resultTotal = 0;
    logic lastAccept  = 1'b0;
    logic chkLatency  = 1'b1;
    logic chkReadyHigh = 1'b0;
    logic holdPrev    = 1'b0;
    logic [W-1:0]  prevRes;
    logic [TW-1:0] prevTag;
    logic          prevRange;

    addsubmod_pipe #(
        .WIDTH   (W),
        .MODULUS (P),
        .TAG_W   (TW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .out_range (out_range)
    );

    always #5 clk = ~clk;

    // Golden mod-P arithmetic written with explicit comparisons.
    function automatic logic [W-1:0] modelRes(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        logic [CW-1:0] s, pe, ae, be;
        pe = {2'b00, P};
        ae = {2'b00, a};
        be = {2'b00, b};
        case (op)
            2'd0: begin
                s = ae + be;
                if (s >= pe) s = s - pe;
            end
            2'd1: s = (ae >= be) ? (ae - be) : (ae + pe - be);
            2'd2: begin
                s = ae + ae;
                if (s >= pe) s = s - pe;
            end
            default: s = (a == '0) ? '0 : (pe - ae);
        endcase
        return W'(s);
    endfunction

    function automatic logic [W-1:0] randOperand();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        v[W-1:W-4] = 4'h0;
        case ($urandom_range(0, 3))
            0: v = W'($urandom_range(0, 255));
            1: v = P - W'($urandom_range(1, 256));
            default: ;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input cmp_t observed, input cmp_t expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample outputs away from the edge, score any hand-off,
    // model any accept, then advance to the next falling edge.
    task automatic tick();
        expect_t e;
        #1;
        if (holdPrev) begin
            checkOutput("stall_valid", cmp_t'(out_valid), cmp_t'(1'b1));
            checkOutput("stall_res",   cmp_t'(out_res),   cmp_t'(prevRes));
            checkOutput("stall_tag",   cmp_t'(out_tag),   cmp_t'(prevTag));
            checkOutput("stall_range", cmp_t'(out_range), cmp_t'(prevRange));
        end
        holdPrev  = out_valid && !out_ready;
        prevRes   = out_res;
        prevTag   = out_tag;
        prevRange = out_range;
        if (chkReadyHigh) checkOutput("in_ready_high", cmp_t'(in_ready), cmp_t'(1'b1));
        if (out_valid && out_ready) begin
            assertCount++;
            assert (scoreQ.size() > 0) else begin
                failCount++;
                $error("[TB] FAIL unexpected_beat observed=%0h expected=none", out_res);
            end
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                resultTotal++;
                if (e.chkRes) checkOutput("res", cmp_t'(out_res), cmp_t'(e.res));
                checkOutput("tag",   cmp_t'(out_tag),   cmp_t'(e.tag));
                checkOutput("range", cmp_t'(out_range), cmp_t'(e.range));
                if (e.chkLat) checkOutput("latency", cmp_t'(cycleNum - e.acceptCycle), cmp_t'(2));
            end
        end
        lastAccept = in_valid && in_ready;
        if (lastAccept) begin
            e.res         = modelRes(in_op, in_a, in_b);
            e.tag         = in_tag;
            e.range       = (in_a >= P) || ((in_b >= P) && (in_op <= 2'd1));
            e.chkRes      = !e.range;
            e.chkLat      = chkLatency;
            e.acceptCycle = cycleNum;
            scoreQ.push_back(e);
            acceptTotal++;
        end
        @(posedge clk);
        cycleNum++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lastAccept) break;
        end
        checkOutput("accept_timeout", cmp_t'(lastAccept), cmp_t'(1'b1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (scoreQ.size() == 0) break;
            tick();
        end
        checkOutput("drain_empty", cmp_t'(scoreQ.size()), cmp_t'(0));
    endtask

    initial begin
        int base;
        $display("[TB] reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_out_valid", cmp_t'(out_valid), cmp_t'(1'b0));
        checkOutput("rst_out_res",   cmp_t'(out_res),   cmp_t'(0));
        checkOutput("rst_out_tag",   cmp_t'(out_tag),   cmp_t'(0));
        checkOutput("rst_out_range", cmp_t'(out_range), cmp_t'(1'b0));
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("rst_in_ready", cmp_t'(in_ready), cmp_t'(1'b1));
        @(negedge clk);

        $display("[TB] directed ops");
        chkLatency = 1'b1;
        applyStimulus(OP_ADD, P - W'(1), W'(1), 8'hA1);
        drain();
        applyStimulus(OP_ADD, W'(5), W'(7), 8'hA2);
        applyStimulus(OP_SUB, W'(3), W'(5), 8'hA3);
        applyStimulus(OP_SUB, W'(5), W'(5), 8'hA4);
        applyStimulus(OP_NEG, W'(0), W'(9), 8'hA5);
        applyStimulus(OP_NEG, W'(1), W'(0), 8'hA6);
        applyStimulus(OP_DBL, P - W'(1), W'(0), 8'hA7);
        drain();

        $display("[TB] random back-to-back");
        base = resultTotal;
        chkReadyHigh = 1'b1;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), randOperand(), randOperand(), 8'(i));
        end
        drain();
        chkReadyHigh = 1'b0;
        checkOutput("random_count", cmp_t'(resultTotal - base), cmp_t'(64));

        $display("[TB] output stall");
        chkLatency = 1'b0;
        base = acceptTotal;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = OP_ADD;
        in_a      = randOperand();
        in_b      = randOperand();
        in_tag    = 8'hC0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (lastAccept) begin
                in_op  = 2'($urandom_range(0, 3));
                in_a   = randOperand();
                in_b   = randOperand();
                in_tag = 8'hC1 + 8'(i);
            end
        end
        #1;
        checkOutput("stall_buffered", cmp_t'(acceptTotal - base), cmp_t'(2));
        checkOutput("stall_in_ready", cmp_t'(in_ready), cmp_t'(1'b0));
        out_ready = 1'b1;
        base = resultTotal;
        applyStimulus(in_op, in_a, in_b, in_tag);
        drain();
        checkOutput("stall_release_count", cmp_t'(resultTotal - base), cmp_t'(3));

        $display("[TB] range flag");
        chkLatency = 1'b1;
        applyStimulus(OP_ADD, P, W'(1), 8'hD1);
        applyStimulus(OP_NEG, W'(5), P, 8'hD2);
        applyStimulus(OP_SUB, W'(2), P, 8'hD3);
        applyStimulus(OP_DBL, W'(3), P, 8'hD4);
        drain();

        $display("[TB] reset with beats in flight");
        applyStimulus(OP_ADD, W'(11), W'(22), 8'hE1);
        applyStimulus(OP_SUB, W'(1), W'(2), 8'hE2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", cmp_t'(out_valid), cmp_t'(1'b0));
        checkOutput("midrst_out_res",   cmp_t'(out_res),   cmp_t'(0));
        scoreQ.delete();
        holdPrev = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checkOutput("post_rst_idle", cmp_t'(out_valid), cmp_t'(1'b0));
        end
        applyStimulus(OP_SUB, W'(9), W'(4), 8'hE3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
